// File: rtl/tt_um_carlosgs99_prod_accum.sv
// ============================================================================
// Module   : tt_um_carlosgs99_prod_accum
// Brief    : Block accumulator for the multiplier product stream (MAC back end).
//            Optional macro ACC_SAT_EN: saturate the sum at 2^AW-1 on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_carlosgs99_prod_accum #(
  parameter int PW = 8,
  parameter int AW = 12,
  parameter int LW = 4
) (
  input  logic          io_clk,
  input  logic          io_rst_n,
  input  logic          io_start,
  input  logic [LW-1:0] io_len,
  input  logic          io_p_valid,
  output logic          io_p_ready,
  input  logic [PW-1:0] io_product,
  output logic [AW-1:0] io_sum,
  output logic          io_sum_valid,
  input  logic          io_sum_ready,
  output logic          io_busy,
  output logic          io_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // A zero length field encodes the longest block, 2^LW products.
  localparam logic [LW:0] c_full_len = {1'b1, {LW{1'b0}}};
  localparam logic [LW:0] c_one      = {{LW{1'b0}}, 1'b1};

  state_t        r_state;
  logic [AW-1:0] r_acc;
  logic [LW:0]   r_cnt;

  logic          w_xfer;
  logic [AW:0]   w_add;
  logic          w_carry;
  logic [AW-1:0] w_acc_nxt;

  assign w_xfer  = io_p_valid & io_p_ready;
  assign w_add   = {1'b0, r_acc} + {{(AW + 1 - PW){1'b0}}, io_product};
  assign w_carry = w_add[AW];

`ifdef ACC_SAT_EN
  // Once pinned at full scale, any non-zero product carries again and stays clamped.
  assign w_acc_nxt = w_carry ? {AW{1'b1}} : w_add[AW-1:0];
`else
  assign w_acc_nxt = w_add[AW-1:0];
`endif

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      io_sum       <= '0;
      io_sum_valid <= 1'b0;
      io_p_ready   <= 1'b0;
      io_busy      <= 1'b0;
      io_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_start) begin
            r_cnt      <= (io_len == '0) ? c_full_len : {1'b0, io_len};
            r_acc      <= '0;
            io_ovf     <= 1'b0;
            io_p_ready <= 1'b1;
            io_busy    <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_xfer) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - c_one;
            if (w_carry) begin
              io_ovf <= 1'b1;
            end
            // Last product of the block: publish the same add result directly.
            if (r_cnt == c_one) begin
              io_sum       <= w_acc_nxt;
              io_sum_valid <= 1'b1;
              io_p_ready   <= 1'b0;
              r_state      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (io_sum_ready) begin
            io_sum_valid <= 1'b0;
            io_busy      <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
